// File: rtl/vend_select_ctrl.sv
// Multi-item vending controller: stores coin credit, reports per-item affordability,
// and runs the dispense and change-return handshakes.
module vend_select_ctrl #(
  parameter int unsigned N_ITEMS    = 4,
  parameter int unsigned CREDIT_W   = 4,
  parameter int unsigned MAX_CREDIT = 8,
  parameter logic [N_ITEMS*CREDIT_W-1:0] PRICES = {4'd8, 4'd6, 4'd5, 4'd5},
  localparam int unsigned SEL_W = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin_valid,
  input  logic [CREDIT_W-1:0] coin_value,
  input  logic                sel_valid,
  input  logic [SEL_W-1:0]    sel_idx,
  input  logic                cancel,
  input  logic                dispense_ready,
  input  logic                change_ready,
  output logic [CREDIT_W-1:0] credit,
  output logic [N_ITEMS-1:0]  affordable,
  output logic                coin_reject,
  output logic                sel_reject,
  output logic                dispense_valid,
  output logic [SEL_W-1:0]    dispense_idx,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_value
);

  typedef enum logic [1:0] {StIdle, StAccum, StVend, StChange} state_e;

  state_e state_q;

  if (MAX_CREDIT >= (2 ** CREDIT_W)) begin : g_bad_max
    $fatal(1, "MAX_CREDIT must fit in CREDIT_W bits");
  end

  for (genvar g = 0; g < N_ITEMS; g++) begin : g_price_check
    if ((PRICES[g*CREDIT_W +: CREDIT_W] == '0) ||
        (int'(PRICES[g*CREDIT_W +: CREDIT_W]) > int'(MAX_CREDIT))) begin : g_bad_price
      $fatal(1, "item price out of range 1..MAX_CREDIT");
    end
  end

  logic                idle_or_accum;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_fits;
  logic                sel_ok;
  logic [CREDIT_W-1:0] sel_price;

  assign idle_or_accum = (state_q == StIdle) || (state_q == StAccum);
  assign coin_sum      = {1'b0, credit} + {1'b0, coin_value};
  assign coin_fits     = (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));

  always_comb begin
    affordable = '0;
    for (int unsigned i = 0; i < N_ITEMS; i++) begin
      affordable[i] = idle_or_accum && (credit >= PRICES[i*CREDIT_W +: CREDIT_W]);
    end
  end

  // Index decode by comparison so an out-of-range sel_idx never selects anything.
  always_comb begin
    sel_ok    = 1'b0;
    sel_price = '0;
    for (int unsigned i = 0; i < N_ITEMS; i++) begin
      if (SEL_W'(i) == sel_idx) begin
        sel_ok    = affordable[i];
        sel_price = PRICES[i*CREDIT_W +: CREDIT_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      credit         <= '0;
      coin_reject    <= 1'b0;
      sel_reject     <= 1'b0;
      dispense_valid <= 1'b0;
      dispense_idx   <= '0;
      change_valid   <= 1'b0;
      change_value   <= '0;
    end else begin
      coin_reject <= 1'b0;
      sel_reject  <= 1'b0;
      unique case (state_q)
        StIdle, StAccum: begin
          // Cancel with no credit is a no-op and does not block a coin or selection.
          if (cancel && (state_q == StAccum)) begin
            change_value <= credit;
            change_valid <= 1'b1;
            credit       <= '0;
            state_q      <= StChange;
            coin_reject  <= coin_valid;
            sel_reject   <= sel_valid;
          end else if (coin_valid) begin
            sel_reject <= sel_valid;
            if (coin_fits) begin
              credit <= coin_sum[CREDIT_W-1:0];
              if (coin_sum != '0) begin
                state_q <= StAccum;
              end
            end else begin
              coin_reject <= 1'b1;
            end
          end else if (sel_valid) begin
            if (sel_ok) begin
              credit         <= credit - sel_price;
              dispense_idx   <= sel_idx;
              dispense_valid <= 1'b1;
              state_q        <= StVend;
            end else begin
              sel_reject <= 1'b1;
            end
          end
        end
        StVend: begin
          coin_reject <= coin_valid;
          sel_reject  <= sel_valid;
          if (dispense_ready) begin
            dispense_valid <= 1'b0;
            if (credit != '0) begin
              change_value <= credit;
              change_valid <= 1'b1;
              credit       <= '0;
              state_q      <= StChange;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        StChange: begin
          coin_reject <= coin_valid;
          sel_reject  <= sel_valid;
          if (change_ready) begin
            change_valid <= 1'b0;
            change_value <= '0;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_select_ctrl.sv
// Scoreboard bench for vend_select_ctrl: a transaction-level model predicts every
// post-edge output set; a monitor pops and compares each cycle.
module tb_vend_select_ctrl;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       coin_valid = 1'b0;
  logic [3:0] coin_value = '0;
  logic       sel_valid = 1'b0;
  logic [1:0] sel_idx = '0;
  logic       cancel = 1'b0;
  logic       dispense_ready = 1'b0;
  logic       change_ready = 1'b0;
  logic [3:0] credit;
  logic [3:0] affordable;
  logic       coin_reject;
  logic       sel_reject;
  logic       dispense_valid;
  logic [1:0] dispense_idx;
  logic       change_valid;
  logic [3:0] change_value;

  vend_select_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .coin_valid(coin_valid), .coin_value(coin_value),
    .sel_valid(sel_valid), .sel_idx(sel_idx), .cancel(cancel),
    .dispense_ready(dispense_ready), .change_ready(change_ready),
    .credit(credit), .affordable(affordable),
    .coin_reject(coin_reject), .sel_reject(sel_reject),
    .dispense_valid(dispense_valid), .dispense_idx(dispense_idx),
    .change_valid(change_valid), .change_value(change_value)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       credit;
    bit [3:0] aff;
    bit       crej;
    bit       srej;
    bit       dv;
    int       di;
    bit       chv;
    int       chval;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  // Reference model: a pending vend/change slot rather than a state register.
  int price[N] = '{5, 5, 6, 8};
  int m_credit, m_didx, m_chamt;
  bit m_vend, m_chg;

  function automatic void model_reset();
    m_credit = 0; m_didx = 0; m_chamt = 0; m_vend = 0; m_chg = 0;
  endfunction

  function automatic exp_t model_step(bit cv, int val, bit sv, int idx, bit can, bit dr, bit cr);
    exp_t e;
    bit rc = 0, rs = 0;
    if (m_vend) begin
      rc = cv; rs = sv;
      if (dr) begin
        m_vend = 0;
        if (m_credit > 0) begin m_chg = 1; m_chamt = m_credit; m_credit = 0; end
      end
    end else if (m_chg) begin
      rc = cv; rs = sv;
      if (cr) begin m_chg = 0; m_chamt = 0; end
    end else if (can && m_credit > 0) begin
      m_chg = 1; m_chamt = m_credit; m_credit = 0; rc = cv; rs = sv;
    end else if (cv) begin
      rs = sv;
      if (m_credit + val <= 8) m_credit += val;
      else rc = 1;
    end else if (sv) begin
      if (idx < N && m_credit >= price[idx]) begin
        m_credit -= price[idx]; m_didx = idx; m_vend = 1;
      end else rs = 1;
    end
    e.credit = m_credit; e.crej = rc; e.srej = rs; e.dv = m_vend; e.di = m_didx;
    e.chv = m_chg; e.chval = m_chamt;
    for (int i = 0; i < N; i++) e.aff[i] = !m_vend && !m_chg && (m_credit >= price[i]);
    return e;
  endfunction

  task automatic check(string name, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  task automatic cyc(bit cv, int val, bit sv, int idx, bit can, bit dr, bit cr);
    @(negedge clk);
    coin_valid = cv; coin_value = 4'(val); sel_valid = sv; sel_idx = 2'(idx);
    cancel = can; dispense_ready = dr; change_ready = cr;
    exp_q.push_back(model_step(cv, val, sv, idx, can, dr, cr));
  endtask

  task automatic idle_cyc();
    cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every active edge produces one predicted output set.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("credit", int'(credit), e.credit);
        check("affordable", int'(affordable), int'(e.aff));
        check("coin_reject", int'(coin_reject), int'(e.crej));
        check("sel_reject", int'(sel_reject), int'(e.srej));
        check("dispense_valid", int'(dispense_valid), int'(e.dv));
        check("dispense_idx", int'(dispense_idx), e.di);
        check("change_valid", int'(change_valid), int'(e.chv));
        check("change_value", int'(change_value), e.chval);
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_credit", int'(credit), 0);
    check("rst_affordable", int'(affordable), 0);
    check("rst_coin_reject", int'(coin_reject), 0);
    check("rst_sel_reject", int'(sel_reject), 0);
    check("rst_dispense_valid", int'(dispense_valid), 0);
    check("rst_dispense_idx", int'(dispense_idx), 0);
    check("rst_change_valid", int'(change_valid), 0);
    check("rst_change_value", int'(change_value), 0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    #1 check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Coins 2 and 3, overflowing coin, unaffordable item 3.
    cyc(1, 2, 0, 0, 0, 0, 0);
    cyc(1, 3, 0, 0, 0, 0, 0);
    cyc(1, 4, 0, 0, 0, 0, 0);
    idle_cyc();
    cyc(0, 0, 1, 3, 0, 0, 0);
    idle_cyc();
    // Reach 8, buy item 2, stall dispense, then change handshake.
    cyc(1, 3, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 2, 0, 0, 0);
    repeat (3) idle_cyc();
    cyc(0, 0, 0, 0, 0, 1, 0);
    idle_cyc();
    cyc(0, 0, 0, 0, 0, 0, 1);
    // Exact-price vend with ready held high.
    cyc(1, 5, 0, 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    idle_cyc();
    // Cancel + coin + sel together at credit 3.
    cyc(1, 3, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 1, 0, 0);
    idle_cyc();
    cyc(0, 0, 0, 0, 0, 0, 1);
    // Reset during CHANGE with change_value 6.
    cyc(1, 6, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    idle_cyc();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    model_reset();
    exp_q.delete();
    coin_valid = 0; sel_valid = 0; cancel = 0; dispense_ready = 0; change_ready = 0;
    @(negedge clk);
    rst_n = 1'b1;
    idle_cyc();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(0, 99) < 35, $urandom_range(0, 5),
          $urandom_range(0, 99) < 30, $urandom_range(0, 3),
          $urandom_range(0, 99) < 6,
          $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 45);
    end
    idle_cyc();
    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
